pe_block_gen: RTL

Parametrised CGRA processing element, the next generation of the fixed two-input ALU-plus-memory PE tile.
- Generalised in input count, output count, data width and scratch-memory depth.
- Adds a registered ALU with accumulate mode, a pipeline stall input, and a double-buffered configuration chain clocked on the datapath clock.
- Instantiated in the array fabric between the inter-PE routing switches; one instance per tile.

---
 rtl/pe_gen_pkg.sv | 52 +++++
 rtl/pe_gen_cfg_chain.sv | 31 +++
 rtl/pe_block_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pe_gen_pkg.sv
// Shared types and layout helpers for the generated PE and its config chain.
// Config layout from LSB: opa, opb, maddr, mdata selects, alu_op, mem_we, out_sel[NUM_OUT].
package pe_gen_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_ACC  = 4'd8,
    OP_MAX  = 4'd9,
    OP_MIN  = 4'd10,
    OP_PASS = 4'd11,
    OP_HOLD = 4'd12
  } alu_op_e;

  localparam logic OUT_ALU = 1'b0;
  localparam logic OUT_MEM = 1'b1;

  // Select fields, in units of SEL_W from bit 0.
  localparam int F_OPA   = 0;
  localparam int F_OPB   = 1;
  localparam int F_MADDR = 2;
  localparam int F_MDATA = 3;
  localparam int NUM_SEL = 4;
  localparam int OP_W    = 4;

  function automatic int sel_w(input int num_in);
    return $clog2(num_in + 2);
  endfunction

  function automatic int cfg_w(input int num_in, input int num_out);
    return NUM_SEL * sel_w(num_in) + OP_W + 1 + num_out;
  endfunction

  function automatic int off_op(input int num_in);
    return NUM_SEL * sel_w(num_in);
  endfunction

  function automatic int off_we(input int num_in);
    return off_op(num_in) + OP_W;
  endfunction

  function automatic int off_out(input int num_in);
    return off_we(num_in) + 1;
  endfunction

endpackage

// File: rtl/pe_gen_cfg_chain.sv
// Double-buffered serial configuration: LSB-first shadow shift register plus active copy.
// A load in the same cycle as a shift captures the pre-shift shadow.
module pe_gen_cfg_chain
  import pe_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic         load,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [W-1:0] active
);

  logic [W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (shift_en) shadow <= {ser_in, shadow[W-1:1]};
      if (load)     active <= shadow;
    end
  end

  assign ser_out = shadow[0];

endmodule

// File: rtl/pe_block_gen.sv
// Parametrised CGRA processing element: crossbar, registered ALU, scratch memory, output mux.
// Optional build macro PE_OUT_REG_EN adds a per-lane output register (2-cycle latency).
module pe_block_gen
  import pe_gen_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int NUM_IN    = 2,
  parameter int NUM_OUT   = 1,
  parameter int MEM_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    config_en,
  input  logic                    config_load,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*SIZE-1:0]  in,
  output logic [NUM_OUT*SIZE-1:0] out
);

  localparam int SEL_W   = sel_w(NUM_IN);
  localparam int CFG_W   = cfg_w(NUM_IN, NUM_OUT);
  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int SH_W    = $clog2(SIZE);
  localparam int OFF_OP  = off_op(NUM_IN);
  localparam int OFF_WE  = off_we(NUM_IN);
  localparam int OFF_OUT = off_out(NUM_IN);

  logic [CFG_W-1:0]                  active;
  logic [NUM_SEL-1:0][SEL_W-1:0]     sel;
  logic [NUM_SEL-1:0][SIZE-1:0]      opnd;
  logic [SIZE-1:0]                   alu_q, alu_nxt, mem_q, a, b;
  logic [OP_W-1:0]                   op;
  logic [AW-1:0]                     addr;
  logic                              we;
  logic [SIZE-1:0]                   mem [MEM_DEPTH];

  pe_gen_cfg_chain #(.W(CFG_W)) u_cfg (
    .clk      (clk),
    .reset    (reset),
    .shift_en (config_en),
    .load     (config_load),
    .ser_in   (config_in),
    .ser_out  (config_out),
    .active   (active)
  );

  assign sel = active[NUM_SEL*SEL_W-1:0];
  assign op  = active[OFF_OP +: OP_W];
  assign we  = active[OFF_WE];

  // Out-of-range selects read as zero; alu_q/mem_q feedback is registered.
  always_comb begin
    for (int j = 0; j < NUM_SEL; j++) begin
      opnd[j] = '0;
      for (int k = 0; k < NUM_IN; k++)
        if (sel[j] == SEL_W'(k)) opnd[j] = in[k*SIZE +: SIZE];
      if (sel[j] == SEL_W'(NUM_IN))     opnd[j] = alu_q;
      if (sel[j] == SEL_W'(NUM_IN + 1)) opnd[j] = mem_q;
    end
  end

  assign a    = opnd[F_OPA];
  assign b    = opnd[F_OPB];
  assign addr = opnd[F_MADDR][AW-1:0];

  logic unused_addr_hi;
  assign unused_addr_hi = ^opnd[F_MADDR][SIZE-1:AW];

  always_comb begin
    alu_nxt = alu_q;
    case (op)
      OP_ADD:  alu_nxt = a + b;
      OP_SUB:  alu_nxt = a - b;
      OP_AND:  alu_nxt = a & b;
      OP_OR:   alu_nxt = a | b;
      OP_XOR:  alu_nxt = a ^ b;
      OP_SHL:  alu_nxt = a << b[SH_W-1:0];
      OP_SHR:  alu_nxt = a >> b[SH_W-1:0];
      OP_MUL:  alu_nxt = a * b;
      OP_ACC:  alu_nxt = alu_q + a;
      OP_MAX:  alu_nxt = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  alu_nxt = ($signed(a) < $signed(b)) ? a : b;
      OP_PASS: alu_nxt = a;
      default: alu_nxt = alu_q;
    endcase
  end

  // config_load clears the datapath registers and wins over en.
  always_ff @(posedge clk) begin
    if (reset || config_load) begin
      alu_q <= '0;
      mem_q <= '0;
    end else if (en) begin
      alu_q <= alu_nxt;
      mem_q <= mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !config_load && en && we) mem[addr] <= opnd[F_MDATA];
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    logic [SIZE-1:0] omux;
    assign omux = (active[OFF_OUT + o] == OUT_MEM) ? mem_q : alu_q;
`ifdef PE_OUT_REG_EN
    logic [SIZE-1:0] oreg;
    always_ff @(posedge clk) begin
      if (reset || config_load) oreg <= '0;
      else if (en)              oreg <= omux;
    end
    assign out[o*SIZE +: SIZE] = oreg;
`else
    assign out[o*SIZE +: SIZE] = omux;
`endif
  end

endmodule
